// File: rtl/rv_pkg.sv
// Shared types and helpers for the writeback stage: load funct3 codes, the
// load-queue entry layout and the byte/half extraction function.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [1:0]      off;
        logic [XLEN-1:0] word;
    } lq_entry_t;

    // Halfword selection uses off[1] only; misaligned halves are not split.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [2:0]      funct3,
        input logic [1:0]      off,
        input logic [XLEN-1:0] word
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   load_extract = {{(XLEN-8){b[7]}}, b};
            F3_LBU:  load_extract = {{(XLEN-8){1'b0}}, b};
            F3_LH:   load_extract = {{(XLEN-16){h[15]}}, h};
            F3_LHU:  load_extract = {{(XLEN-16){1'b0}}, h};
            default: load_extract = word;
        endcase
    endfunction

endpackage

// File: rtl/rv_lq_fifo.sv
// Synchronous FIFO for buffered load responses. Push side is valid/ready,
// pop side is a strobe; the head entry is visible whenever count != 0.
module rv_lq_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_fire;
    logic             pop_fire;

    // Ready comes from the registered count only, so a full queue refuses
    // a push even on the cycle it pops.
    assign push_ready = (count < FULL_CNT);
    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop && (count != '0);
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv_wb_unit.sv
// Writeback stage: merges ALU results with queued load responses onto the
// register-file write port and tracks outstanding loads for decode.
module rv_wb_unit
    import rv_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int XLEN     = rv_pkg::XLEN
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_ld_issue,
    input  logic [4:0]      i_ld_issue_rd,
    input  logic            i_lresp_valid,
    output logic            o_lresp_ready,
    input  logic [4:0]      i_lresp_rd,
    input  logic [2:0]      i_lresp_funct3,
    input  logic [1:0]      i_lresp_off,
    input  logic [XLEN-1:0] i_lresp_word,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic [31:0]     o_pending
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;

    lq_entry_t     push_entry;
    lq_entry_t     head;
    logic [CW-1:0] lq_count;
    logic          ld_sel;
    logic [31:0]   pending_next;

    assign push_entry = '{rd: i_lresp_rd, funct3: i_lresp_funct3,
                          off: i_lresp_off, word: i_lresp_word};

    // Handshake: a response transfers on any edge where i_lresp_valid and
    // o_lresp_ready are both high; the ALU path has no back-pressure.
    rv_lq_fifo #(
        .DEPTH (LQ_DEPTH),
        .WIDTH ($bits(lq_entry_t))
    ) lq (
        .clk        (i_clk),
        .reset      (i_reset),
        .push_valid (i_lresp_valid),
        .push_ready (o_lresp_ready),
        .push_data  (push_entry),
        .pop        (ld_sel),
        .head       (head),
        .count      (lq_count)
    );

    assign ld_sel = !i_alu_valid && (lq_count != '0);

    always_comb begin
        pending_next = o_pending;
        if (ld_sel)                           pending_next[head.rd] = 1'b0;
        if (i_ld_issue)                       pending_next[i_ld_issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_rd_wren <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
            o_pending <= '0;
        end else begin
            o_pending <= pending_next;
            if (i_alu_valid) begin
                o_rd_wren <= (i_alu_rd != 5'd0);
                o_rd_addr <= i_alu_rd;
                o_rd_data <= i_alu_data;
            end else if (ld_sel) begin
                o_rd_wren <= (head.rd != 5'd0);
                o_rd_addr <= head.rd;
                o_rd_data <= load_extract(head.funct3, head.off, head.word);
            end else begin
                o_rd_wren <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rv_wb_unit.sv
// Directed bench for rv_wb_unit with hand-computed expectations.
module tb_rv_wb_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        lresp_valid;
    logic        lresp_ready;
    logic [4:0]  lresp_rd;
    logic [2:0]  lresp_funct3;
    logic [1:0]  lresp_off;
    logic [31:0] lresp_word;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_wren;
    logic [31:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_wb_unit #(.LQ_DEPTH(2), .XLEN(32)) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_alu_valid    (alu_valid),
        .i_alu_rd       (alu_rd),
        .i_alu_data     (alu_data),
        .i_ld_issue     (ld_issue),
        .i_ld_issue_rd  (ld_issue_rd),
        .i_lresp_valid  (lresp_valid),
        .o_lresp_ready  (lresp_ready),
        .i_lresp_rd     (lresp_rd),
        .i_lresp_funct3 (lresp_funct3),
        .i_lresp_off    (lresp_off),
        .i_lresp_word   (lresp_word),
        .o_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_rd_wren      (rd_wren),
        .o_pending      (pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_resp(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] word);
        lresp_rd     = rd;
        lresp_funct3 = f3;
        lresp_off    = off;
        lresp_word   = word;
    endtask

    // One accepted response, queue and ALU idle beforehand.
    task automatic push_one(input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] word);
        set_resp(rd, f3, off, word);
        lresp_valid = 1'b1;
        step();
        lresp_valid = 1'b0;
    endtask

    task automatic check_ld(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] off, input logic [31:0] exp);
        push_one(rd, f3, off, 32'h8070_F0A5);
        step();
        check({tag, "_wren"}, {31'd0, rd_wren}, 32'd1);
        check({tag, "_addr"}, {27'd0, rd_addr}, {27'd0, rd});
        check({tag, "_data"}, rd_data, exp);
    endtask

    initial begin
        reset = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; lresp_valid = 1'b0;
        set_resp(5'd0, 3'd0, 2'd0, 32'd0);
        step();
        step();
        reset = 1'b0;
        check("rst_wren", {31'd0, rd_wren}, 32'd0);
        check("rst_addr", {27'd0, rd_addr}, 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_pending", pending, 32'd0);
        check("rst_ready", {31'd0, lresp_ready}, 32'd1);

        // ALU path
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678;
        step();
        check("alu_wren", {31'd0, rd_wren}, 32'd1);
        check("alu_addr", {27'd0, rd_addr}, 32'd5);
        check("alu_data", rd_data, 32'h1234_5678);
        alu_rd = 5'd0; alu_data = 32'hDEAD_BEEF;
        step();
        check("alu_x0_wren", {31'd0, rd_wren}, 32'd0);
        alu_valid = 1'b0;
        step();
        check("idle_wren", {31'd0, rd_wren}, 32'd0);
        check("idle_hold_data", rd_data, 32'hDEAD_BEEF);

        // Load extraction on word 0x8070_F0A5
        check_ld("lb0",  5'd1, 3'b000, 2'd0, 32'hFFFF_FFA5);
        check_ld("lbu1", 5'd2, 3'b100, 2'd1, 32'h0000_00F0);
        check_ld("lh2",  5'd3, 3'b001, 2'd2, 32'hFFFF_8070);
        check_ld("lhu3", 5'd4, 3'b101, 2'd3, 32'h0000_8070);
        check_ld("lw",   5'd5, 3'b010, 2'd1, 32'h8070_F0A5);
        check_ld("lb3",  5'd6, 3'b000, 2'd3, 32'hFFFF_FF80);
        check_ld("raw",  5'd8, 3'b011, 2'd2, 32'h8070_F0A5);

        // Collision: ALU x3 and queued x4 present on the same edge
        push_one(5'd4, 3'b010, 2'd0, 32'h0000_0044);
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0033;
        step();
        alu_valid = 1'b0;
        check("col_alu_addr", {27'd0, rd_addr}, 32'd3);
        check("col_alu_data", rd_data, 32'h0000_0033);
        step();
        check("col_ld_addr", {27'd0, rd_addr}, 32'd4);
        check("col_ld_data", rd_data, 32'h0000_0044);

        // Three-cycle ALU stream delays the queued x6
        set_resp(5'd6, 3'b010, 2'd0, 32'h0000_0066);
        lresp_valid = 1'b1;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h0000_0010;
        step();
        lresp_valid = 1'b0;
        check("str_a10", {27'd0, rd_addr}, 32'd10);
        alu_rd = 5'd11; alu_data = 32'h0000_0011;
        step();
        check("str_a11", {27'd0, rd_addr}, 32'd11);
        alu_rd = 5'd12; alu_data = 32'h0000_0012;
        step();
        check("str_a12", {27'd0, rd_addr}, 32'd12);
        alu_valid = 1'b0;
        step();
        check("str_ld_addr", {27'd0, rd_addr}, 32'd6);
        check("str_ld_data", rd_data, 32'h0000_0066);

        // Back-pressure with the ALU holding the write port
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0000_0099;
        lresp_valid = 1'b1; set_resp(5'd13, 3'b010, 2'd0, 32'h0000_00A1);
        step();
        check("bp_ready_1", {31'd0, lresp_ready}, 32'd1);
        check("bp_alu_addr", {27'd0, rd_addr}, 32'd9);
        set_resp(5'd14, 3'b010, 2'd0, 32'h0000_00A2);
        step();
        check("bp_ready_2", {31'd0, lresp_ready}, 32'd0);
        set_resp(5'd15, 3'b010, 2'd0, 32'h0000_00A3);
        step();
        check("bp_ready_3", {31'd0, lresp_ready}, 32'd0);
        check("bp_count", 32'(dut.lq_count), 32'd2);
        alu_valid = 1'b0;
        step();
        check("bp_w13_addr", {27'd0, rd_addr}, 32'd13);
        check("bp_w13_data", rd_data, 32'h0000_00A1);
        check("bp_ready_4", {31'd0, lresp_ready}, 32'd1);
        step();
        lresp_valid = 1'b0;
        check("bp_w14_addr", {27'd0, rd_addr}, 32'd14);
        check("bp_w14_data", rd_data, 32'h0000_00A2);
        step();
        check("bp_w15_addr", {27'd0, rd_addr}, 32'd15);
        check("bp_w15_data", rd_data, 32'h0000_00A3);
        step();
        check("bp_drained_wren", {31'd0, rd_wren}, 32'd0);
        check("bp_drained_count", 32'(dut.lq_count), 32'd0);

        // Scoreboard
        ld_issue = 1'b1; ld_issue_rd = 5'd7;
        step();
        ld_issue = 1'b0;
        check("sb_set", pending, 32'h0000_0080);
        push_one(5'd7, 3'b010, 2'd0, 32'h0000_0077);
        check("sb_held", pending, 32'h0000_0080);
        step();
        check("sb_clr", pending, 32'h0000_0000);
        check("sb_clr_addr", {27'd0, rd_addr}, 32'd7);
        check("sb_clr_wren", {31'd0, rd_wren}, 32'd1);
        ld_issue = 1'b1;
        step();
        ld_issue = 1'b0;
        push_one(5'd7, 3'b010, 2'd0, 32'h0000_0078);
        ld_issue = 1'b1;
        step();
        ld_issue = 1'b0;
        check("sb_setwins_data", rd_data, 32'h0000_0078);
        check("sb_setwins", pending, 32'h0000_0080);
        push_one(5'd7, 3'b010, 2'd0, 32'h0000_0079);
        step();
        check("sb_clr2", pending, 32'h0000_0000);

        // x0 never pending, x0 response consumed without a write
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        step();
        ld_issue = 1'b0;
        check("x0_pending", pending, 32'h0000_0000);
        push_one(5'd0, 3'b010, 2'd0, 32'h0000_0055);
        check("x0_queued", 32'(dut.lq_count), 32'd1);
        step();
        check("x0_wren", {31'd0, rd_wren}, 32'd0);
        check("x0_consumed", 32'(dut.lq_count), 32'd0);

        // Reset in the middle of activity
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
        ld_issue = 1'b1; ld_issue_rd = 5'd4;
        lresp_valid = 1'b1; set_resp(5'd4, 3'b010, 2'd0, 32'h0000_0004);
        step();
        ld_issue_rd = 5'd7; set_resp(5'd7, 3'b010, 2'd0, 32'h0000_0007);
        step();
        ld_issue = 1'b0;
        check("mid_pending", pending, 32'h0000_0090);
        check("mid_count", 32'(dut.lq_count), 32'd2);
        check("mid_ready", {31'd0, lresp_ready}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0; alu_valid = 1'b0; lresp_valid = 1'b0;
        check("mrst_count", 32'(dut.lq_count), 32'd0);
        check("mrst_pending", pending, 32'h0000_0000);
        check("mrst_wren", {31'd0, rd_wren}, 32'd0);
        check("mrst_ready", {31'd0, lresp_ready}, 32'd1);
        step();
        check("mrst_after_wren", {31'd0, rd_wren}, 32'd0);
        check("mrst_after_count", 32'(dut.lq_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
